// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit type, digit limits and validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // A digit code above 9 cannot be shown on a decade display.
  function automatic logic bcd_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : Single BCD decade register with load, up/down step and
//               9/0 detection for ripple carry and borrow chains.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // Illegal codes are stored as zero so the digit never leaves 0-9.
      digit_d = bcd_invalid(load_digit) ? BCD_MIN : load_digit;
    end else if (step) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : Multi-digit BCD up/down counter with enable, parallel load,
//               cascadable terminal count. Load path enabled by macro
//               BCD_COUNTER_LOAD_EN; otherwise the counter is count/hold only.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  logic              load_eff;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] digit_bad;

`ifdef BCD_COUNTER_LOAD_EN
  logic load_err_q;
  logic load_err_d;

  assign load_eff   = load;
  assign load_err_d = load & (|digit_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`else
  logic w_unused_load;

  assign w_unused_load = load ^ (|digit_bad);
  assign load_eff      = 1'b0;
  assign load_err      = 1'b0;
`endif

  // Load takes priority, so no digit steps on a load edge.
  assign step[0] = en & ~load_eff;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_bad[gi] = bcd_invalid(load_val[4*gi +: 4]);

      if (gi > 0) begin : g_chain
        assign step[gi] = step[gi-1] & (up ? at_max[gi-1] : at_min[gi-1]);
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .step       (step[gi]),
        .up         (up),
        .load       (load_eff),
        .load_digit (load_val[4*gi +: 4]),
        .digit      (count[4*gi +: 4]),
        .at_max     (at_max[gi]),
        .at_min     (at_min[gi])
      );
    end
  endgenerate

  assign tc = en & (up ? (&at_max) : (&at_min));

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter
// Description : Directed self-checking bench for bcd_updown_counter (DIGITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic        load_err;

  int total;
  int bad;

  bcd_updown_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 16'h0000;
    #12;
    chk("reset_count", {16'h0, count}, 32'h0000);
    chk("reset_lerr", {31'h0, load_err}, 32'h0);
    chk("reset_tc_en0", {31'h0, tc}, 32'h0);
    en = 1'b1;
    #1;
    chk("reset_tc_up", {31'h0, tc}, 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Down from zero wraps to all nines
    en = 1'b1;
    up = 1'b0;
    #1;
    chk("tc_down_zero", {31'h0, tc}, 32'h1);
    tick();
    chk("wrap_down", {16'h0, count}, 32'h9999);
    chk("tc_down_9999", {31'h0, tc}, 32'h0);
    up = 1'b1;
    #1;
    chk("tc_up_9999", {31'h0, tc}, 32'h1);
    tick();
    chk("wrap_up", {16'h0, count}, 32'h0000);
    chk("tc_after_wrap", {31'h0, tc}, 32'h0);

    // Count up to 0998 then across the hundreds carry
    repeat (998) tick();
    chk("up_0998", {16'h0, count}, 32'h0998);
    chk("tc_0998", {31'h0, tc}, 32'h0);
    tick();
    chk("up_0999", {16'h0, count}, 32'h0999);
    chk("tc_0999", {31'h0, tc}, 32'h0);
    tick();
    chk("up_1000", {16'h0, count}, 32'h1000);

    // Direction change takes effect on the very next edge
    up = 1'b0;
    tick();
    chk("down_0999", {16'h0, count}, 32'h0999);
    tick();
    chk("down_0998", {16'h0, count}, 32'h0998);

    en = 1'b0;
    tick();
    chk("hold", {16'h0, count}, 32'h0998);

`ifdef BCD_COUNTER_LOAD_EN
    load     = 1'b1;
    load_val = 16'h12A4;
    en       = 1'b1;
    tick();
    chk("load_invalid", {16'h0, count}, 32'h1204);
    chk("lerr_set", {31'h0, load_err}, 32'h1);
    load = 1'b0;
    en   = 1'b0;
    tick();
    chk("lerr_clear", {31'h0, load_err}, 32'h0);
    chk("load_hold", {16'h0, count}, 32'h1204);
    load     = 1'b1;
    load_val = 16'h9999;
    tick();
    chk("load_9999", {16'h0, count}, 32'h9999);
    chk("lerr_valid", {31'h0, load_err}, 32'h0);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    #1;
    chk("tc_loaded", {31'h0, tc}, 32'h1);
    tick();
    chk("wrap_loaded", {16'h0, count}, 32'h0000);
    load     = 1'b1;
    load_val = 16'h0998;
    tick();
    load = 1'b0;
    tick();
    chk("load_then_up", {16'h0, count}, 32'h0999);
    en = 1'b0;
`else
    load     = 1'b1;
    load_val = 16'h5555;
    tick();
    chk("load_ignored", {16'h0, count}, 32'h0998);
    chk("lerr_tied", {31'h0, load_err}, 32'h0);
    load_val = 16'h12A4;
    tick();
    chk("lerr_tied_bad", {31'h0, load_err}, 32'h0);
    load = 1'b0;
`endif

    // Asynchronous reset away from the clock edge
    en = 1'b1;
    up = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {16'h0, count}, 32'h0000);
    chk("async_rst_lerr", {31'h0, load_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("first_step", {16'h0, count}, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
